down_counter_timer: RTL and testbench

- Loadable WIDTH-bit down-counter/timer: counts a programmed value down to zero on qualified ticks and reports terminal count with a start/busy/done handshake.
- Counterpart to the team's T-flip-flop ripple-enable up-counter. It is the down-counting consumer used for delays, timeouts and periodic strobes.

---
 rtl/down_counter_timer_pkg.sv | 13 +
 rtl/down_counter_timer_if.sv | 38 +++
 rtl/down_counter_timer_core.sv | 46 ++++
 rtl/down_counter_timer.sv | 91 +++++++++
 tb/tb_down_counter_timer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter/timer block.
//   state_e       : controller states (idle / counting)
//   DEFAULT_WIDTH : default counter and load-value width in bits
package down_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down-counter/timer.
//   i_load        : capture i_value into reload (and count when idle)
//   i_value       : load/reload value
//   i_start       : begin countdown (idle only)
//   i_enable      : tick qualifier
//   i_auto_reload : 1 = periodic, 0 = one-shot
//   i_abort       : stop countdown without done
//   o_Q           : current count
//   o_busy        : high while counting
//   o_done        : one-cycle terminal-count pulse
//   o_zero        : count equals zero
// master drives the controls, slave is the timer.
interface down_counter_timer_if
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             i_load;
    logic [WIDTH-1:0] i_value;
    logic             i_start;
    logic             i_enable;
    logic             i_auto_reload;
    logic             i_abort;
    logic [WIDTH-1:0] o_Q;
    logic             o_busy;
    logic             o_done;
    logic             o_zero;

    modport master (
        output i_load, i_value, i_start, i_enable, i_auto_reload, i_abort,
        input  o_Q, o_busy, o_done, o_zero
    );

    modport slave (
        input  i_load, i_value, i_start, i_enable, i_auto_reload, i_abort,
        output o_Q, o_busy, o_done, o_zero
    );
endinterface

// File: rtl/down_counter_timer_core.sv
// WIDTH-bit T-flip-flop down-counter with parallel load and async clear.
//   clk        : clock, rising edge
//   clear      : asynchronous active-high clear (q <= 0)
//   load       : parallel load of load_value (wins over en)
//   load_value : value to load
//   en         : decrement by one
//   q          : current count
// Bit k toggles when en is high and all lower bits are zero: the borrow chain
// of a down-counter, i.e. the up-counter enable chain on inverted Q.
module tff_down_core
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] mask;

    always_comb begin
        toggle = '0;
        mask   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            // mask selects bits below k; empty for bit 0
            mask      = (WIDTH'(1) << k) - WIDTH'(1);
            toggle[k] = en & ((q & mask) == '0);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else begin
            q <= q ^ toggle;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with start/busy/done handshake.
//   i_clk   : clock, rising edge
//   i_clear : asynchronous active-high reset
//   bus     : control/status bundle (slave side), see down_counter_timer_if
// Counts a programmed value down to zero on enabled ticks; one-shot or
// periodic (auto-reload) operation, abortable, with a registered done pulse.
module down_counter_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_clear,
    down_counter_timer_if.slave  bus
);

    state_e           state_q;
    logic [WIDTH-1:0] reload_q;
    logic             done_q;
    logic [WIDTH-1:0] count;

    logic             is_run;
    logic             start_zero;
    logic             terminal;
    logic             do_reload;
    logic             core_load;
    logic [WIDTH-1:0] core_value;
    logic             core_en;

    assign is_run     = (state_q == StRun);
    // Load and start together start from the freshly loaded value.
    assign start_zero = ((bus.i_load ? bus.i_value : count) == '0);
    assign terminal   = is_run & ~bus.i_abort & bus.i_enable & (count == WIDTH'(1));
    assign do_reload  = terminal & bus.i_auto_reload & (reload_q != '0);
    assign core_load  = (~is_run & bus.i_load) | do_reload;
    assign core_value = is_run ? reload_q : bus.i_value;
    // count != 0 guard keeps the counter from ever wrapping to all-ones.
    assign core_en    = is_run & ~bus.i_abort & bus.i_enable & (count != '0);

    tff_down_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (i_clk),
        .clear      (i_clear),
        .load       (core_load),
        .load_value (core_value),
        .en         (core_en),
        .q          (count)
    );

    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            state_q  <= StIdle;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.i_load) begin
                reload_q <= bus.i_value;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        if (start_zero) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (bus.i_abort) begin
                        state_q <= StIdle;
                    end else if (terminal) begin
                        done_q <= 1'b1;
                        if (!do_reload) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_Q    = count;
    assign bus.o_busy = is_run;
    assign bus.o_done = done_q;
    assign bus.o_zero = (count == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: each directed step pushes the
// hand-computed post-edge outputs; a monitor pops and compares after every edge.
module tb_down_counter_timer;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       zero;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_clear;
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;
    exp_t exp_q[$];

    down_counter_timer_if #(.WIDTH(8)) bus ();

    down_counter_timer #(
        .WIDTH (8)
    ) dut (
        .i_clk   (i_clk),
        .i_clear (i_clear),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: outputs are presented every cycle; compare one entry per edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.o_Q, bus.o_busy, bus.o_done, bus.o_zero};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL step_out q/busy/done/zero: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                             a.q, a.busy, a.done, a.zero, e.q, e.busy, e.done, e.zero);
                end
            end
        end
    end

    task automatic step(input logic ld, input logic [7:0] val, input logic st,
                        input logic en, input logic ar, input logic ab,
                        input logic [7:0] eq, input logic eb, input logic ed);
        exp_t e;
        @(negedge i_clk);
        bus.i_load        = ld;
        bus.i_value       = val;
        bus.i_start       = st;
        bus.i_enable      = en;
        bus.i_auto_reload = ar;
        bus.i_abort       = ab;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        e.zero = (eq == 8'd0);
        exp_q.push_back(e);
        step_no++;
    endtask

    task automatic direct_check(input string name, input logic [7:0] q, input logic b,
                                input logic d, input logic z);
        checks++;
        if ({bus.o_Q, bus.o_busy, bus.o_done, bus.o_zero} !== {q, b, d, z}) begin
            failures++;
            $display("FAIL %s q/busy/done/zero: got %0d/%b/%b/%b want %0d/%b/%b/%b", name,
                     bus.o_Q, bus.o_busy, bus.o_done, bus.o_zero, q, b, d, z);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge i_clk);
            #2;
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        i_clear           = 1'b1;
        bus.i_load        = 1'b0;
        bus.i_value       = 8'd0;
        bus.i_start       = 1'b0;
        bus.i_enable      = 1'b0;
        bus.i_auto_reload = 1'b0;
        bus.i_abort       = 1'b0;
        #3;
        direct_check("reset", 8'd0, 1'b0, 1'b0, 1'b1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_clear = 1'b0;

        // One-shot from 3
        //   ld  val     st  en  ar  ab    Q       busy done
        step(1, 8'd3,   1,  1,  0,  0,    8'd3,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd2,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd1,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd0,   0,   1);
        step(0, 8'd0,   0,  1,  0,  0,    8'd0,   0,   0);

        // Gated ticks from 2
        step(1, 8'd2,   1,  0,  0,  0,    8'd2,   1,   0);
        step(0, 8'd0,   0,  0,  0,  0,    8'd2,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd1,   1,   0);
        step(0, 8'd0,   0,  0,  0,  0,    8'd1,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd0,   0,   1);
        step(0, 8'd0,   0,  0,  0,  0,    8'd0,   0,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd0,   0,   0);

        // Auto-reload period 4, then reload changed to 200 mid-run
        step(1, 8'd4,   1,  1,  1,  0,    8'd4,   1,   0);
        step(0, 8'd0,   0,  1,  1,  0,    8'd3,   1,   0);
        step(0, 8'd0,   0,  1,  1,  0,    8'd2,   1,   0);
        step(0, 8'd0,   0,  1,  1,  0,    8'd1,   1,   0);
        step(0, 8'd0,   0,  1,  1,  0,    8'd4,   1,   1);
        step(0, 8'd0,   1,  1,  1,  0,    8'd3,   1,   0);
        step(1, 8'd200, 0,  1,  1,  0,    8'd2,   1,   0);
        step(0, 8'd0,   0,  1,  1,  0,    8'd1,   1,   0);
        step(0, 8'd0,   0,  1,  1,  0,    8'd200, 1,   1);
        step(0, 8'd0,   0,  1,  1,  0,    8'd199, 1,   0);
        step(0, 8'd0,   0,  1,  1,  1,    8'd199, 0,   0);

        // Zero start
        step(1, 8'd0,   1,  1,  0,  0,    8'd0,   0,   1);
        step(0, 8'd0,   0,  1,  0,  0,    8'd0,   0,   0);
        step(0, 8'd0,   1,  1,  0,  0,    8'd0,   0,   1);
        step(0, 8'd0,   0,  0,  0,  0,    8'd0,   0,   0);

        // Abort at 7, idle ignores enable, restart resumes from 7
        step(1, 8'd10,  1,  1,  0,  0,    8'd10,  1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd9,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd8,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd7,   1,   0);
        step(0, 8'd0,   0,  1,  0,  1,    8'd7,   0,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd7,   0,   0);
        step(0, 8'd0,   1,  1,  0,  0,    8'd7,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd6,   1,   0);
        step(0, 8'd0,   0,  1,  0,  1,    8'd6,   0,   0);

        // Reset mid-run
        step(1, 8'd5,   1,  1,  0,  0,    8'd5,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd4,   1,   0);
        step(0, 8'd0,   0,  1,  0,  0,    8'd3,   1,   0);
        drain();
        #1;
        direct_check("pre_clear", 8'd3, 1'b1, 1'b0, 1'b0);
        i_clear = 1'b1;
        #1;
        direct_check("async_clear", 8'd0, 1'b0, 1'b0, 1'b1);
        @(negedge i_clk);
        i_clear = 1'b0;
        step(0, 8'd0,   0,  1,  0,  0,    8'd0,   0,   0);
        step(0, 8'd0,   0,  1,  1,  0,    8'd0,   0,   0);
        step(0, 8'd0,   0,  0,  0,  0,    8'd0,   0,   0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
